// File: rtl/regfile_wb_arbiter.sv
// Arbitrates two writeback requesters onto the single registered regfile write port and tracks pending writes.
// Build option: define WB_RR_ARB_EN for round-robin on contention; otherwise r0 has fixed priority.
module regfile_wb_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 r0_valid,
  output logic                 r0_ready,
  input  logic [AW-1:0]        r0_addr,
  input  logic [DW-1:0]        r0_data,
  input  logic                 r1_valid,
  output logic                 r1_ready,
  input  logic [AW-1:0]        r1_addr,
  input  logic [DW-1:0]        r1_data,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_addr,
  output logic                 we3,
  output logic [AW-1:0]        wa3,
  output logic [DW-1:0]        wd3,
  output logic [(2**AW)-1:0]   pending,
  output logic                 last_grant
);

  localparam int NR = 2**AW;

  logic          we3_q, we3_d;
  logic [AW-1:0] wa3_q, wa3_d;
  logic [DW-1:0] wd3_q, wd3_d;
  logic [NR-1:0] pend_q, pend_d;
  logic          last_q, last_d;

  logic          gnt0, gnt1, hs;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_data;

`ifdef WB_RR_ARB_EN
  // rr_q = 1 means r1 wins the next contended cycle
  logic rr_q, rr_d;
`endif

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
`ifdef WB_RR_ARB_EN
      gnt0 = r0_valid && (!r1_valid || !rr_q);
`else
      gnt0 = r0_valid;
`endif
      gnt1 = r1_valid && !gnt0;
    end
  end

  assign hs     = gnt0 | gnt1;
  assign g_addr = gnt1 ? r1_addr : r0_addr;
  assign g_data = gnt1 ? r1_data : r0_data;

  always_comb begin
    we3_d  = 1'b0;
    wa3_d  = wa3_q;
    wd3_d  = wd3_q;
    last_d = last_q;
    if (hs) begin
      we3_d  = (g_addr != '0);
      wa3_d  = g_addr;
      wd3_d  = g_data;
      last_d = gnt1;
    end
  end

`ifdef WB_RR_ARB_EN
  always_comb begin
    rr_d = rr_q;
    if (hs && r0_valid && r1_valid) begin
      rr_d = gnt0;
    end
  end
`endif

  // Per-register scoreboard: a same-edge issue beats the writeback clear
  generate
    for (genvar gi = 0; gi < NR; gi++) begin : g_pend
      if (gi == 0) begin : g_zero
        assign pend_d[gi] = 1'b0;
      end else begin : g_reg
        localparam logic [AW-1:0] IDX = AW'(gi);
        assign pend_d[gi] = (iss_valid && (iss_addr == IDX)) ||
                            (pend_q[gi] && !(hs && (g_addr == IDX)));
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      we3_q  <= 1'b0;
      wa3_q  <= '0;
      wd3_q  <= '0;
      pend_q <= '0;
      last_q <= 1'b0;
    end else begin
      we3_q  <= we3_d;
      wa3_q  <= wa3_d;
      wd3_q  <= wd3_d;
      pend_q <= pend_d;
      last_q <= last_d;
    end
  end

`ifdef WB_RR_ARB_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

  assign r0_ready   = gnt0;
  assign r1_ready   = gnt1;
  assign we3        = we3_q;
  assign wa3        = wa3_q;
  assign wd3        = wd3_q;
  assign pending    = pend_q;
  assign last_grant = last_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios followed by random traffic, all checked against a behavioural model.
module tb_regfile_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          r0_valid, r1_valid, iss_valid;
  logic          r0_ready, r1_ready;
  logic [AW-1:0] r0_addr, r1_addr, iss_addr;
  logic [DW-1:0] r0_data, r1_data;
  logic          we3;
  logic [AW-1:0] wa3;
  logic [DW-1:0] wd3;
  logic [31:0]   pending;
  logic          last_grant;

  int checks   = 0;
  int failures = 0;

  // Model state
  logic          m_we;
  logic [AW-1:0] m_wa;
  logic [DW-1:0] m_wd;
  logic [31:0]   m_pend;
  logic          m_last;
  int            m_fav;     // requester that wins the next contended cycle
  logic          g0_prev, g1_prev;

  regfile_wb_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .r0_valid   (r0_valid),
    .r0_ready   (r0_ready),
    .r0_addr    (r0_addr),
    .r0_data    (r0_data),
    .r1_valid   (r1_valid),
    .r1_ready   (r1_ready),
    .r1_addr    (r1_addr),
    .r1_data    (r1_data),
    .iss_valid  (iss_valid),
    .iss_addr   (iss_addr),
    .we3        (we3),
    .wa3        (wa3),
    .wd3        (wd3),
    .pending    (pending),
    .last_grant (last_grant)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: check readies mid-cycle, predict the edge, then check registered outputs.
  task automatic step();
    logic          g0, g1, both;
    int            winner;
    logic          n_we, n_last;
    logic [AW-1:0] n_wa;
    logic [DW-1:0] n_wd;
    logic [31:0]   n_pend;
    int            n_fav;
    @(negedge clk);
    g0 = 1'b0;
    g1 = 1'b0;
    both = r0_valid && r1_valid;
    if (!reset) begin
      if (both) begin
`ifdef WB_RR_ARB_EN
        winner = m_fav;
`else
        winner = 0;
`endif
        g0 = (winner == 0);
        g1 = (winner == 1);
      end else begin
        g0 = r0_valid;
        g1 = r1_valid;
      end
    end
    check("r0_ready", {63'd0, r0_ready}, {63'd0, g0});
    check("r1_ready", {63'd0, r1_ready}, {63'd0, g1});

    n_we = 1'b0; n_wa = m_wa; n_wd = m_wd; n_pend = m_pend; n_last = m_last; n_fav = m_fav;
    if (reset) begin
      n_wa = '0; n_wd = '0; n_pend = '0; n_last = 1'b0; n_fav = 0;
    end else begin
      if (g0 || g1) begin
        n_wa   = g1 ? r1_addr : r0_addr;
        n_wd   = g1 ? r1_data : r0_data;
        n_we   = (n_wa != 0);
        n_last = g1;
        if (both) n_fav = g1 ? 0 : 1;
        n_pend[n_wa] = 1'b0;
        $display("WB req=%0d addr=%0d data=%08h", g1 ? 1 : 0, n_wa, n_wd);
      end
      if (iss_valid) n_pend[iss_addr] = 1'b1;
      n_pend[0] = 1'b0;
    end

    @(posedge clk);
    #1;
    m_we = n_we; m_wa = n_wa; m_wd = n_wd; m_pend = n_pend; m_last = n_last; m_fav = n_fav;
    g0_prev = g0; g1_prev = g1;
    check("we3",        {63'd0, we3},        {63'd0, m_we});
    check("wa3",        {59'd0, wa3},        {59'd0, m_wa});
    check("wd3",        {32'd0, wd3},        {32'd0, m_wd});
    check("pending",    {32'd0, pending},    {32'd0, m_pend});
    check("last_grant", {63'd0, last_grant}, {63'd0, m_last});
  endtask

  task automatic idle_inputs();
    r0_valid = 1'b0; r1_valid = 1'b0; iss_valid = 1'b0;
    r0_addr = '0; r1_addr = '0; iss_addr = '0;
    r0_data = '0; r1_data = '0;
  endtask

  initial begin
    m_we = 1'b0; m_wa = '0; m_wd = '0; m_pend = '0; m_last = 1'b0; m_fav = 0;
    g0_prev = 1'b0; g1_prev = 1'b0;
    idle_inputs();
    reset = 1'b1;
    #1;
    step();
    step();
    reset = 1'b0;
    step();

    // Single write by r0
    r0_valid = 1'b1; r0_addr = 5'd1; r0_data = 32'h1;
    step();
    idle_inputs();
    step();

    // Issue to $zero, then r1 writes $zero and is dropped
    iss_valid = 1'b1; iss_addr = 5'd0;
    step();
    idle_inputs();
    r1_valid = 1'b1; r1_addr = 5'd0; r1_data = 32'hDEAD;
    step();
    idle_inputs();
    step();

    // Contention: loser holds, winner drops after its grant
    r0_valid = 1'b1; r0_addr = 5'd3; r0_data = 32'hA;
    r1_valid = 1'b1; r1_addr = 5'd4; r1_data = 32'hB;
    for (int i = 0; i < 2; i++) begin
      step();
      if (g0_prev) r0_valid = 1'b0;
      if (g1_prev) r1_valid = 1'b0;
    end
    idle_inputs();
    step();

    // Scoreboard: set, set-wins-over-clear, then clear
    iss_valid = 1'b1; iss_addr = 5'd7;
    step();
    r1_valid = 1'b1; r1_addr = 5'd7; r1_data = 32'h77;
    step();
    idle_inputs();
    r0_valid = 1'b1; r0_addr = 5'd7; r0_data = 32'h78;
    step();
    idle_inputs();
    step();

    // Reset in the middle of a pending write to register 9
    iss_valid = 1'b1; iss_addr = 5'd9;
    step();
    idle_inputs();
    r0_valid = 1'b1; r0_addr = 5'd9; r0_data = 32'h99;
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle_inputs();
    step();

    // Random traffic; an ungranted valid request is held stable
    for (int c = 0; c < 800; c++) begin
      if (!r0_valid || g0_prev) begin
        r0_valid = ($urandom_range(0, 99) < 60);
        r0_addr  = AW'($urandom_range(0, 31));
        r0_data  = $urandom;
      end
      if (!r1_valid || g1_prev) begin
        r1_valid = ($urandom_range(0, 99) < 50);
        r1_addr  = AW'($urandom_range(0, 31));
        r1_data  = $urandom;
      end
      iss_valid = ($urandom_range(0, 99) < 40);
      iss_addr  = AW'($urandom_range(0, 31));
      reset     = ($urandom_range(0, 99) < 3);
      step();
    end

    reset = 1'b0;
    idle_inputs();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (we3/wa3/wd3) between two writeback requesters: r0 = ALU/load writeback, r1 = multi-cycle unit (mul/div).
- Uses a valid/ready handshake per requester and drives registered write-port signals into regfile.
- Keeps a 32-bit pending-write scoreboard so issue/hazard logic can stall on registers awaiting writeback.

Parameters:
- DW, 32, data width of wd3 and requester data.
- AW, 5, register address width; register count is 2**AW.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- r0_valid  input  1  requester 0 has a write pending
- r0_ready  output  1  requester 0 granted this cycle (combinational)
- r0_addr  input  AW  requester 0 destination register
- r0_data  input  DW  requester 0 write data
- r1_valid  input  1  requester 1 has a write pending
- r1_ready  output  1  requester 1 granted this cycle (combinational)
- r1_addr  input  AW  requester 1 destination register
- r1_data  input  DW  requester 1 write data
- iss_valid  input  1  instruction issued with a destination register
- iss_addr  input  AW  destination register of the issued instruction
- we3  output  1  regfile write enable (registered)
- wa3  output  AW  regfile write address (registered)
- wd3  output  DW  regfile write data (registered)
- pending  output  2**AW  scoreboard bit per register; 1 = write outstanding
- last_grant  output  1  requester granted at the most recent handshake (0/1)

Behaviour:
- Reset (synchronous, checked every edge, overrides everything):
  - we3=0, wa3=0, wd3=0, pending=0, last_grant=0.
  - RR pointer prefers r0.
  - No grant while reset is high: r0_ready=r1_ready=0.
- Handshake: transfer occurs when rX_valid && rX_ready.
  - At most one ready per cycle.
  - Ready depends only on valids, arbitration state and reset, never on the other requester's data.
- Arbitration, one valid: that requester is granted in the same cycle.
- Arbitration, both valid: per the priority rule (see Optional Feature).
  - The loser holds its valid, addr and data stable until granted; the bench checks this as an assumption.
- Write latency is 1 cycle. On the edge that accepts a handshake:
  - wa3 <= granted addr, wd3 <= granted data.
  - we3 <= 1 if addr != 0, else we3 <= 0. A write to $zero is acknowledged and dropped.
- Idle cycle (no handshake): we3 <= 0 on the next edge; wa3/wd3 hold their last values.
- Throughput: one write per cycle, back-to-back, no bubble.
- last_grant updates only on a handshake edge.
- Scoreboard update on each edge:
  - iss_valid sets pending[iss_addr].
  - A handshake clears pending[granted addr].
  - Same address set and cleared on the same edge: set wins (newer issue outstanding).
  - Different addresses: both take effect.
  - pending[0] is constant 0; issue to 0 is ignored.
- Clearing a register that is not pending is legal and is a no-op.
- Reset mid-operation: any in-flight handshake on that edge is discarded; we3=0 on the next cycle; pending cleared.

Optional Feature:
- Macro WB_RR_ARB_EN.
- Defined: round-robin when both valid. The requester not granted at the last contended handshake wins. Pointer flips after each contended grant and is unchanged by uncontended grants. Reset value favours r0.
- Undefined: fixed priority; r0 always wins contention and r1 waits while r0_valid=1 (starvation permitted by design). last_grant behaviour is identical in both builds.

Test Plan:
- Reset then idle: assert reset 2 cycles -> we3=0, wa3=0, wd3=0, pending=0, r0_ready=r1_ready=0 during reset.
- Single write: r0_valid=1, r0_addr=5'd1, r0_data=32'h1 for one cycle -> r0_ready=1 that cycle; next cycle we3=1, wa3=1, wd3=32'h1; following cycle we3=0.
- Zero-register drop: iss_valid with iss_addr=0, then r1 writes addr 0, data 32'hDEAD -> r1_ready=1; next cycle we3=0; pending[0]=0 throughout.
- Contention:
  - r0 writes (3, 32'hA) and r1 writes (4, 32'hB), both valid for 2 cycles.
  - With WB_RR_ARB_EN: r0 granted first, then r1.
  - Without it: r0 granted, r1 granted after r0_valid drops.
  - Write port shows 3/A then 4/B on consecutive cycles.
- Scoreboard:
  - iss_valid addr 7 -> pending[7]=1 next cycle.
  - r1 writes addr 7 on the same edge as iss_valid addr 7 -> pending[7] stays 1.
  - Later r0 writes addr 7 alone -> pending[7]=0.
- Reset mid-stream: r0_valid=1 addr 9 with pending[9]=1, reset high on that edge -> next cycle we3=0, pending=0, no write to 9 observed.
